buzzer_tone_gen: RTL and testbench

- Square-wave tone generator that drives the piano's PWM speaker pin from a 5-bit note index.
- Sits under the auto-player and free-play controllers, which update `note` every clock.
- Index 0 means silence. Indices 1..21 select three diatonic octaves (C..B).
- Output is a 50 % duty square wave at the selected pitch.

---
 rtl/piano_pkg.sv | 57 +++++
 rtl/buzzer_tone_gen_lut.sv | 21 ++
 rtl/buzzer_tone_gen.sv | 48 ++++
 tb/tb_buzzer_tone_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared piano definitions: note encoding, diatonic frequency table (C4..B6)
// and elaboration-time half-period helpers used by the tone and player blocks.
package piano_pkg;

    localparam int NOTE_W   = 5;
    localparam int NOTE_MAX = 21;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t NOTE_REST = '0;

    // Indices 1..7 = C4..B4, 8..14 = C5..B5, 15..21 = C6..B6; anything else has no pitch.
    function automatic int unsigned note_freq(input note_t idx);
        int unsigned f;
        f = 0;
        case (idx)
            5'd1:  f = 262;
            5'd2:  f = 294;
            5'd3:  f = 330;
            5'd4:  f = 349;
            5'd5:  f = 392;
            5'd6:  f = 440;
            5'd7:  f = 494;
            5'd8:  f = 523;
            5'd9:  f = 587;
            5'd10: f = 659;
            5'd11: f = 698;
            5'd12: f = 784;
            5'd13: f = 880;
            5'd14: f = 988;
            5'd15: f = 1047;
            5'd16: f = 1175;
            5'd17: f = 1319;
            5'd18: f = 1397;
            5'd19: f = 1568;
            5'd20: f = 1760;
            5'd21: f = 1976;
            default: f = 0;
        endcase
        return f;
    endfunction

    function automatic logic is_rest(input note_t idx);
        return (idx == NOTE_REST) || (idx > note_t'(NOTE_MAX));
    endfunction

    // Truncating clk_hz / (2*f); rests map to 0 so callers never divide by zero.
    function automatic int unsigned half_period(input int unsigned clk_hz, input note_t idx);
        int unsigned h;
        h = 0;
        if (!is_rest(idx)) begin
            h = clk_hz / (32'd2 * note_freq(idx));
        end
        return h;
    endfunction

endpackage

// File: rtl/buzzer_tone_gen_lut.sv
// Combinational note index to half-period lookup; the table is folded to
// constants at elaboration and rests read back as zero.
module note_half_period_lut
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          CNT_W  = 20
) (
    input  logic [NOTE_W-1:0] note,
    output logic [CNT_W-1:0]  half
);

    logic [CNT_W-1:0] half_tab [32];

    for (genvar k = 0; k < 32; k++) begin : g_tab
        assign half_tab[k] = CNT_W'(half_period(CLK_HZ, NOTE_W'(k)));
    end

    assign half = half_tab[note];

endmodule

// File: rtl/buzzer_tone_gen.sv
// 50 % duty square-wave buzzer driver; the phase restarts whenever the
// accepted note changes and the output is held low during rests.
module buzzer_tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int          CNT_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note,
    output logic              speaker
);

    logic [CNT_W-1:0]  cnt;
    logic [NOTE_W-1:0] note_q;
    logic [CNT_W-1:0]  half;

    note_half_period_lut #(
        .CLK_HZ (CLK_HZ),
        .CNT_W  (CNT_W)
    ) u_lut (
        .note (note_q),
        .half (half)
    );

    // Note changes win over toggling so a new pitch always starts from a low phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            note_q  <= NOTE_REST;
            speaker <= 1'b0;
        end else if (note != note_q) begin
            note_q  <= note;
            cnt     <= '0;
            speaker <= 1'b0;
        end else if (is_rest(note_q)) begin
            cnt     <= '0;
            speaker <= 1'b0;
        end else if (cnt == half - CNT_W'(1)) begin
            cnt     <= '0;
            speaker <= ~speaker;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Self-checking bench for buzzer_tone_gen, run at a scaled-down clock rate so
// every tone fits in a few hundred cycles.
module tb_buzzer_tone_gen;

    localparam int unsigned CLK_TB = 200_000;
    localparam int          BOUND  = 4 * 381 + 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] note;
    logic       speaker;

    int checks = 0;
    int errors = 0;

    int unsigned freq_tb [0:21] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                    523, 587, 659, 698, 784, 880, 988,
                                    1047, 1175, 1319, 1397, 1568, 1760, 1976};

    buzzer_tone_gen #(
        .CLK_HZ (CLK_TB),
        .CNT_W  (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .note    (note),
        .speaker (speaker)
    );

    always #5 clk = ~clk;

    function automatic int unsigned half_tb(input logic [4:0] n);
        if (n == 5'd0 || n > 5'd21) return 0;
        return CLK_TB / (2 * freq_tb[n]);
    endfunction

    // Reference: remember which edge the current pitch started on; the output is the
    // parity of whole half-periods elapsed since then.
    int unsigned edge_n  = 0;
    int unsigned m_start = 0;
    logic [4:0]  m_note  = 5'd0;

    always @(posedge clk) begin
        if (rst) begin
            m_note  <= 5'd0;
            m_start <= edge_n;
        end else if (note != m_note) begin
            m_note  <= note;
            m_start <= edge_n;
        end
        edge_n <= edge_n + 1;
    end

    function automatic logic model_speaker();
        int unsigned h;
        int unsigned elapsed;
        h = half_tb(m_note);
        if (h == 0) return 1'b0;
        elapsed = edge_n - 1 - m_start;
        return ((elapsed / h) % 2) == 1;
    endfunction

    // Counts negedges until speaker equals level (inclusive); -1 if the bound expires.
    task automatic wait_level(input logic level, input int bound, output int cycles);
        cycles = 0;
        forever begin
            @(negedge clk);
            cycles++;
            if (speaker === level) return;
            if (cycles > bound) begin
                cycles = -1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst  = 1'b1;
        note = 5'd8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (speaker !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_speaker cyc %0d: got %b expected 0", i, speaker);
            end
            checks++;
            if (dut.cnt !== 20'd0) begin
                errors++;
                $display("[TB] FAIL reset_cnt cyc %0d: got %0d expected 0", i, dut.cnt);
            end
        end
        rst = 1'b0;
        wait_level(1'b1, BOUND, cyc);
        checks++;
        if (cyc - 1 !== int'(half_tb(5'd8))) begin
            errors++;
            $display("[TB] FAIL reset_first_rise: got %0d expected %0d", cyc - 1, half_tb(5'd8));
        end
    endtask

    task automatic test_tone();
        int rise, hi, lo;
        int h;
        h = int'(half_tb(5'd6));
        note = 5'd6;
        wait_level(1'b1, BOUND, rise);
        wait_level(1'b0, BOUND, hi);
        wait_level(1'b1, BOUND, lo);
        checks++;
        if (rise - 1 !== h) begin
            errors++;
            $display("[TB] FAIL tone_first_rise: got %0d expected %0d", rise - 1, h);
        end
        checks++;
        if (hi !== h) begin
            errors++;
            $display("[TB] FAIL tone_high_time: got %0d expected %0d", hi, h);
        end
        checks++;
        if (lo !== h) begin
            errors++;
            $display("[TB] FAIL tone_low_time: got %0d expected %0d", lo, h);
        end
        checks++;
        if (hi + lo !== 2 * h) begin
            errors++;
            $display("[TB] FAIL tone_period: got %0d expected %0d", hi + lo, 2 * h);
        end
    endtask

    task automatic test_rest(input logic [4:0] rest_note);
        int cyc;
        int bad;
        note = 5'd13;
        wait_level(1'b1, BOUND, cyc);
        repeat (10) @(negedge clk);
        checks++;
        if (speaker !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rest_pre_high note %0d: got %b expected 1", rest_note, speaker);
        end
        note = rest_note;
        @(negedge clk);
        checks++;
        if (speaker !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rest_next_edge note %0d: got %b expected 0", rest_note, speaker);
        end
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (speaker !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL rest_hold note %0d: got %0d high cycles expected 0", rest_note, bad);
        end
    endtask

    task automatic test_phase_restart();
        int cyc;
        note = 5'd21;
        repeat (300) @(negedge clk);
        note = 5'd1;
        @(negedge clk);
        checks++;
        if (speaker !== 1'b0) begin
            errors++;
            $display("[TB] FAIL restart_change_edge: got %b expected 0", speaker);
        end
        wait_level(1'b1, BOUND, cyc);
        checks++;
        if (cyc !== int'(half_tb(5'd1))) begin
            errors++;
            $display("[TB] FAIL restart_first_rise: got %0d expected %0d", cyc, half_tb(5'd1));
        end
    endtask

    task automatic test_same_note();
        int cyc;
        int gap;
        logic level;
        note = 5'd10;
        wait_level(1'b1, BOUND, cyc);
        level = 1'b0;
        for (int t = 0; t < 4; t++) begin
            gap = 0;
            forever begin
                note = 5'd10;
                @(negedge clk);
                gap++;
                if (speaker === level || gap > BOUND) break;
            end
            checks++;
            if (gap !== int'(half_tb(5'd10))) begin
                errors++;
                $display("[TB] FAIL same_note_spacing toggle %0d: got %0d expected %0d", t, gap, half_tb(5'd10));
            end
            level = ~level;
        end
    endtask

    task automatic test_mid_reset();
        int cyc;
        note = 5'd12;
        wait_level(1'b1, BOUND, cyc);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (speaker !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_speaker: got %b expected 0", speaker);
        end
        rst = 1'b0;
        wait_level(1'b1, BOUND, cyc);
        checks++;
        if (cyc - 1 !== int'(half_tb(5'd12))) begin
            errors++;
            $display("[TB] FAIL mid_reset_first_rise: got %0d expected %0d", cyc - 1, half_tb(5'd12));
        end
    endtask

    task automatic test_random();
        logic [4:0] n;
        logic       exp;
        int         hold;
        n = note;
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 3) != 0) n = 5'($urandom_range(0, 31));
            rst  = ($urandom_range(0, 7) == 0);
            note = n;
            hold = $urandom_range(1, 500);
            for (int c = 0; c < hold; c++) begin
                @(negedge clk);
                rst = 1'b0;
                exp = model_speaker();
                checks++;
                if (speaker !== exp) begin
                    errors++;
                    $display("[TB] FAIL random seg %0d cyc %0d note %0d: got %b expected %b", s, c, n, speaker, exp);
                end
            end
        end
    endtask

    initial begin
        rst  = 1'b1;
        note = 5'd8;
        test_reset();
        test_tone();
        test_rest(5'd0);
        test_rest(5'd25);
        test_phase_restart();
        test_same_note();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
